// File: rtl/alu_muldiv_unit.sv
// ----------------------------------------------------------------------------
// alu_muldiv_unit
//   Iterative RV32M multiply/divide unit that sits in EX beside the ALU.
//   Multiply is radix-2 shift-add and divide is restoring. Each retires one bit
//   per cycle on operand magnitudes, and the sign is fixed up in a final
//   adjust cycle. Divide-by-zero and signed overflow bypass the iteration and
//   complete in one cycle.
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   flush              kills any in-flight op at the next edge
//   in_valid/in_ready  op handshake (in_ready only in IDLE with flush low)
//   op                 funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b               rs1 / rs2 operands, sampled only at accept
//   tag_in             destination tag carried with the op
//   out_valid/out_ready result handshake
//   result, tag_out    registered result and its tag
//   zero               result == 0
//   busy               unit not idle
// ----------------------------------------------------------------------------
module alu_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                neg_q, neg_d;          // product/quotient sign differs
  logic                rem_neg_q, rem_neg_d;  // remainder follows dividend sign
  logic [2*XLEN-1:0]   prod_q, prod_d;        // {accumulator, multiplier}
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;          // dividend shifts out, quotient in
  logic [XLEN-1:0]     dvsr_q, dvsr_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [TAG_W-1:0]    tag_out_q, tag_out_d;

  logic                signed_a, signed_b, sa, sb;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift, div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix;

  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign tag_out   = tag_out_q;
  assign zero      = (result_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    tag_out_d = tag_out_q;

    // Operand sign decode: MUL only needs the low half, which is sign-agnostic.
    signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sa       = signed_a && a[XLEN-1];
    sb       = signed_b && b[XLEN-1];
    a_mag    = sa ? -a : a;
    b_mag    = sb ? -b : b;

    // Multiply step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole product right by one.
    mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

    // Restoring divide step. The trial subtraction is XLEN+1 bits wide, so its
    // top bit is a borrow flag (shifted remainder < divisor).
    div_shift = {rem_q, quo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, dvsr_q};
    div_ge    = !div_diff[XLEN];

    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = neg_q ? -quo_q : quo_q;
    rem_fix  = rem_neg_q ? -rem_q : rem_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d      = op;
            tag_d     = tag_in;
            neg_d     = sa ^ sb;
            rem_neg_d = sa;
            prod_d    = {{XLEN{1'b0}}, b_mag};
            mcand_d   = a_mag;
            rem_d     = '0;
            quo_d     = a_mag;
            dvsr_d    = b_mag;
            cnt_d     = '0;
            if (op[2] && (b == '0)) begin
              // Divide by zero: quotient all-ones, remainder is the dividend.
              result_d  = op[1] ? a : '1;
              tag_out_d = tag_in;
              state_d   = DONE;
            end else if (((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1)) begin
              // Signed overflow: quotient wraps to MIN_NEG, remainder is zero.
              result_d  = op[1] ? '0 : MIN_NEG;
              tag_out_d = tag_in;
              state_d   = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          cnt_d = cnt_q + 1'b1;
          if (op_q[2]) begin
            rem_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], div_ge};
          end else begin
            prod_d = {mul_sum, prod_q[XLEN-1:1]};
          end
          if (cnt_q == CNT_LAST) begin
            state_d = ADJ;
          end
        end
        ADJ: begin
          case (op_q)
            3'b000:          result_d = prod_fix[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:          result_d = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:  result_d = quo_fix;
            default:         result_d = rem_fix;
          endcase
          tag_out_d = tag_q;
          state_d   = DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      prod_q    <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
      tag_out_q <= tag_out_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_muldiv_unit
//   Directed self-checking bench for alu_muldiv_unit at XLEN=32, TAG_W=5.
//   Latency is counted as the number of clock edges after the accept edge
//   at which out_valid is first seen high (0 for the fast path, 33 otherwise).
// ----------------------------------------------------------------------------
module tb_alu_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = 3'b000;
  logic [XLEN-1:0]  a = '0;
  logic [XLEN-1:0]  b = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;
  logic             zero;
  logic             busy;

  int compared   = 0;
  int mismatched = 0;

  alu_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .tag_out   (tag_out),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s: observed %h expected %h", name, obs, exp);
      $error("check %s", name);
    end
  endtask

  // Issue one op, wait for its result, optionally stall the consumer, then take it.
  task automatic run_op(input string name, input logic [2:0] o,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] t, input logic [31:0] exp,
                        input int exp_lat, input int hold);
    int lat;
    check({name, " in_ready before"}, 32'(in_ready), 32'd1);
    op = o; a = av; b = bv; tag_in = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs after accept; they must not affect the op in flight.
    op = 3'($urandom); a = $urandom; b = $urandom; tag_in = 5'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, result, exp);
    check({name, " tag"}, 32'(tag_out), 32'(t));
    check({name, " zero"}, 32'(zero), 32'(exp == 32'd0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, " hold result"}, result, exp);
      check({name, " hold in_ready"}, 32'(in_ready), 32'd0);
      check({name, " hold out_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " out_valid after take"}, 32'(out_valid), 32'd0);
    check({name, " in_ready after take"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset tag_out", 32'(tag_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset zero", 32'(zero), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Iterative ops
    run_op("MUL 7*-3",        3'b000, 32'd7,          32'hFFFF_FFFD, 5'd17, 32'hFFFF_FFEB, 33, 0);
    run_op("MULHU ff*ff",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33, 0);
    run_op("MULH -1*-1",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000, 33, 0);
    run_op("MULHSU -1*ff",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFF, 33, 0);
    run_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 33, 0);
    run_op("REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 33, 0);
    run_op("DIVU 100/7 hold", 3'b101, 32'd100,        32'd7,         5'd8,  32'd14,        33, 10);
    run_op("REMU 100/7",      3'b111, 32'd100,        32'd7,         5'd9,  32'd2,         33, 0);

    // Fast path
    run_op("DIV by 0",        3'b100, 32'd5,          32'd0,         5'd10, 32'hFFFF_FFFF, 0, 0);
    run_op("REM by 0",        3'b110, 32'h1234_5678, 32'd0,         5'd11, 32'h1234_5678, 0, 0);
    run_op("DIVU by 0",       3'b101, 32'd9,          32'd0,         5'd12, 32'hFFFF_FFFF, 0, 0);
    run_op("DIV ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0, 0);
    run_op("REM ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 0, 0);

    // Flush at cycle 10 of CALC
    op = 3'b000; a = 32'd3; b = 32'd5; tag_in = 5'd21; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush in_ready while flush", 32'(in_ready), 32'd0);
    check("flush busy before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush in_ready next", 32'(in_ready), 32'd1);
    check("flush busy after", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("flush out_valid never", 32'(seen), 32'd0);

    // A normal op to leave a nonzero result before the reset test
    run_op("MUL 3*5",         3'b000, 32'd3,          32'd5,         5'd22, 32'd15,        33, 0);

    // Asynchronous reset mid-CALC
    op = 3'b100; a = 32'd1000; b = 32'd3; tag_in = 5'd30; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst result", result, 32'd0);
    check("async rst tag_out", 32'(tag_out), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset
    run_op("DIVU 100/7 post", 3'b101, 32'd100,        32'd7,         5'd2,  32'd14,        33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
